// File: rtl/pipe_mem_arbiter_if.sv
// pipe_mem_arbiter_if
// Bundles the two requester handshakes (instruction fetch and MEM stage) with
// the single Wishbone classic master bus that they share.
//   master modport : the arbiter side. It takes requests and read data and
//                    drives acks, rdata, bus_err and the wb_*_o bus outputs.
//   slave modport  : the environment side. It drives the requests, wb_dat_i
//                    and wb_ack_i, and observes everything else.
interface pipe_mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // instruction fetch requester
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ack;
  logic [DATA_WIDTH-1:0] if_rdata;
  // MEM stage requester
  logic                  mem_req;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [3:0]            mem_sel;
  logic                  mem_ack;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic                  bus_err;
  // Wishbone classic master bus
  logic                  wb_cyc_o;
  logic                  wb_stb_o;
  logic                  wb_we_o;
  logic [ADDR_WIDTH-1:0] wb_adr_o;
  logic [DATA_WIDTH-1:0] wb_dat_o;
  logic [3:0]            wb_sel_o;
  logic [DATA_WIDTH-1:0] wb_dat_i;
  logic                  wb_ack_i;

  modport master (
    input  if_req, if_addr,
    output if_ack, if_rdata,
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    output mem_ack, mem_rdata, bus_err,
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i
  );

  modport slave (
    output if_req, if_addr,
    input  if_ack, if_rdata,
    output mem_req, mem_we, mem_addr, mem_wdata, mem_sel,
    input  mem_ack, mem_rdata, bus_err,
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i
  );
endinterface

// File: rtl/pipe_mem_arbiter.sv
// pipe_mem_arbiter
// Shares one Wishbone classic master port between instruction fetch (read
// only) and the MEM stage (load/store). Each access runs IDLE -> BUS_x -> DONE.
// A bus access that sees no wb_ack_i for TIMEOUT cycles is aborted, returns
// ERR_DATA and pulses bus_err. The block also derives the pipeline
// freeze/bubble controls from the outstanding requests.
// Ports:
//   clk       : clock, rising edge
//   reset     : asynchronous active-low reset
//   bus       : requester handshakes plus the Wishbone bus (master modport)
//   pc_stall  : hold the PC
//   ifid_fs, idex_fs, exmem_fs, memwb_fs : per pipeline register, [1]=flush,
//               [0]=stall
module pipe_mem_arbiter #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    TIMEOUT    = 255,
  parameter logic [DATA_WIDTH-1:0] ERR_DATA   = 32'hDEAD_BEEF
) (
  input  logic                 clk,
  input  logic                 reset,
  pipe_mem_arbiter_if.master   bus,
  output logic                 pc_stall,
  output logic [1:0]           ifid_fs,
  output logic [1:0]           idex_fs,
  output logic [1:0]           exmem_fs,
  output logic [1:0]           memwb_fs
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUS_IF  = 2'd1,
    ST_BUS_MEM = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // The bus-cycle counter is 16 bits wide so it covers the full TIMEOUT range.
  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT);

  state_t                state_r;
  logic [15:0]           cnt_r;
  logic                  cyc_r;
  logic                  we_r;
  logic [ADDR_WIDTH-1:0] adr_r;
  logic [DATA_WIDTH-1:0] dat_r;
  logic [3:0]            sel_r;
  logic                  if_ack_r;
  logic [DATA_WIDTH-1:0] if_rdata_r;
  logic                  mem_ack_r;
  logic [DATA_WIDTH-1:0] mem_rdata_r;
  logic                  bus_err_r;

  logic                  mem_busy_s;
  logic                  if_busy_s;
  logic                  pc_stall_s;
  logic [1:0]            ifid_fs_s;
  logic [1:0]            idex_fs_s;
  logic [1:0]            exmem_fs_s;
  logic [1:0]            memwb_fs_s;

  // Arbitration FSM, bus sequencing, timeout and all registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 16'd0;
      cyc_r       <= 1'b0;
      we_r        <= 1'b0;
      adr_r       <= '0;
      dat_r       <= '0;
      sel_r       <= 4'd0;
      if_ack_r    <= 1'b0;
      if_rdata_r  <= '0;
      mem_ack_r   <= 1'b0;
      mem_rdata_r <= '0;
      bus_err_r   <= 1'b0;
    end else begin
      // Acks and bus_err are single-cycle pulses, set only on entry to DONE.
      if_ack_r  <= 1'b0;
      mem_ack_r <= 1'b0;
      bus_err_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 16'd0;
          // MEM has priority; a waiting fetch is picked up on the next IDLE.
          if (bus.mem_req) begin
            cyc_r   <= 1'b1;
            we_r    <= bus.mem_we;
            adr_r   <= bus.mem_addr;
            dat_r   <= bus.mem_wdata;
            sel_r   <= bus.mem_sel;
            state_r <= ST_BUS_MEM;
          end else if (bus.if_req) begin
            cyc_r   <= 1'b1;
            we_r    <= 1'b0;
            adr_r   <= bus.if_addr;
            sel_r   <= 4'hF;
            state_r <= ST_BUS_IF;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUS_IF, ST_BUS_MEM: begin
          // An ack in the final allowed cycle wins over the timeout.
          if (bus.wb_ack_i) begin
            cyc_r   <= 1'b0;
            state_r <= ST_DONE;
            if (state_r == ST_BUS_IF) begin
              if_rdata_r <= bus.wb_dat_i;
              if_ack_r   <= 1'b1;
            end else begin
              if (!we_r) begin
                mem_rdata_r <= bus.wb_dat_i;
              end else begin
                mem_rdata_r <= mem_rdata_r;
              end
              mem_ack_r <= 1'b1;
            end
          end else if ((cnt_r + 16'd1) == TIMEOUT_LIM) begin
            cyc_r     <= 1'b0;
            bus_err_r <= 1'b1;
            state_r   <= ST_DONE;
            if (state_r == ST_BUS_IF) begin
              if_rdata_r <= ERR_DATA;
              if_ack_r   <= 1'b1;
            end else begin
              if (!we_r) begin
                mem_rdata_r <= ERR_DATA;
              end else begin
                mem_rdata_r <= mem_rdata_r;
              end
              mem_ack_r <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DONE: begin
          // Requests are deliberately ignored here: the requester is still
          // dropping or changing its request on this edge.
          cnt_r   <= 16'd0;
          state_r <= ST_IDLE;
        end
        default: begin
          cyc_r   <= 1'b0;
          cnt_r   <= 16'd0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  // Pipeline freeze/bubble control from the live requests and their acks.
  always_comb begin
    mem_busy_s = bus.mem_req & ~mem_ack_r;
    if_busy_s  = bus.if_req & ~if_ack_r;
    pc_stall_s = 1'b0;
    ifid_fs_s  = 2'b00;
    idex_fs_s  = 2'b00;
    exmem_fs_s = 2'b00;
    memwb_fs_s = 2'b00;
    if (mem_busy_s) begin
      // Freeze IF..MEM, feed bubbles into WB.
      pc_stall_s = 1'b1;
      ifid_fs_s  = 2'b01;
      idex_fs_s  = 2'b01;
      exmem_fs_s = 2'b01;
      memwb_fs_s = 2'b10;
    end else if (if_busy_s) begin
      // Hold the PC, bubble into ID, let the rest of the pipe drain.
      pc_stall_s = 1'b1;
      ifid_fs_s  = 2'b10;
    end else begin
      pc_stall_s = 1'b0;
      ifid_fs_s  = 2'b00;
    end
  end

  assign bus.wb_cyc_o  = cyc_r;
  assign bus.wb_stb_o  = cyc_r;
  assign bus.wb_we_o   = we_r;
  assign bus.wb_adr_o  = adr_r;
  assign bus.wb_dat_o  = dat_r;
  assign bus.wb_sel_o  = sel_r;
  assign bus.if_ack    = if_ack_r;
  assign bus.if_rdata  = if_rdata_r;
  assign bus.mem_ack   = mem_ack_r;
  assign bus.mem_rdata = mem_rdata_r;
  assign bus.bus_err   = bus_err_r;

  assign pc_stall = pc_stall_s;
  assign ifid_fs  = ifid_fs_s;
  assign idex_fs  = idex_fs_s;
  assign exmem_fs = exmem_fs_s;
  assign memwb_fs = memwb_fs_s;

endmodule

// File: tb/tb_pipe_mem_arbiter.sv
// Directed testbench for pipe_mem_arbiter (TIMEOUT=4).
module tb_pipe_mem_arbiter;
  logic       clk;
  logic       reset;
  logic       pc_stall;
  logic [1:0] ifid_fs, idex_fs, exmem_fs, memwb_fs;
  int         n_tests;
  int         n_fail;

  pipe_mem_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bif ();

  pipe_mem_arbiter #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(4), .ERR_DATA(32'hDEAD_BEEF)
  ) dut (
    .clk(clk), .reset(reset), .bus(bif), .pc_stall(pc_stall),
    .ifid_fs(ifid_fs), .idex_fs(idex_fs), .exmem_fs(exmem_fs), .memwb_fs(memwb_fs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Watchdog: the run is fully directed, this only guards against a hang.
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {pc_stall, ifid, idex, exmem, memwb} as one 9-bit vector
  function automatic logic [8:0] fs_vec();
    return {pc_stall, ifid_fs, idex_fs, exmem_fs, memwb_fs};
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    bif.if_req = 1'b0; bif.if_addr = 32'h0;
    bif.mem_req = 1'b0; bif.mem_we = 1'b0; bif.mem_addr = 32'h0;
    bif.mem_wdata = 32'h0; bif.mem_sel = 4'h0;
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    tick(); tick();
    n_tests++;
    if ({bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.if_ack, bif.mem_ack, bif.bus_err} !== 10'd0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b expected 0", {bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.if_ack, bif.mem_ack, bif.bus_err});
    end
    n_tests++;
    if ({bif.wb_adr_o, bif.wb_dat_o, bif.if_rdata, bif.mem_rdata} !== 128'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {bif.wb_adr_o, bif.wb_dat_o, bif.if_rdata, bif.mem_rdata});
    end
    n_tests++;
    if (fs_vec() !== 9'd0) begin
      n_fail++; $display("FAIL reset_fs: got %b expected 0", fs_vec());
    end
    #2 reset = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    // cycle 0
    bif.if_req = 1'b1; bif.if_addr = 32'h8000_0000;
    #1;
    n_tests++;
    if ({fs_vec(), bif.wb_cyc_o} !== {9'b1_10_00_00_00, 1'b0}) begin
      n_fail++; $display("FAIL fetch_c0: got %b expected %b", {fs_vec(), bif.wb_cyc_o}, {9'b1_10_00_00_00, 1'b0});
    end
    tick(); // cycle 1
    n_tests++;
    if ({bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o} !== {3'b110, 4'hF, 32'h8000_0000}) begin
      n_fail++; $display("FAIL fetch_c1_bus: got %h expected %h", {bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o}, {3'b110, 4'hF, 32'h8000_0000});
    end
    tick(); // cycle 2: slave acks
    bif.wb_ack_i = 1'b1; bif.wb_dat_i = 32'h0000_0013;
    #1;
    n_tests++;
    if ({bif.wb_cyc_o, bif.if_ack, fs_vec()} !== {2'b10, 9'b1_10_00_00_00}) begin
      n_fail++; $display("FAIL fetch_c2: got %b expected %b", {bif.wb_cyc_o, bif.if_ack, fs_vec()}, {2'b10, 9'b1_10_00_00_00});
    end
    tick(); // cycle 3: if_ack
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    n_tests++;
    if ({bif.wb_cyc_o, bif.if_ack, bif.bus_err, bif.if_rdata} !== {3'b010, 32'h0000_0013}) begin
      n_fail++; $display("FAIL fetch_ack: got %h expected %h", {bif.wb_cyc_o, bif.if_ack, bif.bus_err, bif.if_rdata}, {3'b010, 32'h0000_0013});
    end
    n_tests++;
    if (fs_vec() !== 9'd0) begin
      n_fail++; $display("FAIL fetch_ack_fs: got %b expected 0", fs_vec());
    end
    bif.if_req = 1'b0;
    tick(); // cycle 4
    n_tests++;
    if ({bif.wb_cyc_o, bif.if_ack, bif.if_rdata} !== {2'b00, 32'h0000_0013}) begin
      n_fail++; $display("FAIL fetch_hold: got %h expected %h", {bif.wb_cyc_o, bif.if_ack, bif.if_rdata}, {2'b00, 32'h0000_0013});
    end
  endtask

  task automatic test_collision();
    bif.if_req = 1'b1; bif.if_addr = 32'h8000_0004;
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h8000_0100; bif.mem_sel = 4'hF;
    #1;
    n_tests++;
    if (fs_vec() !== 9'b1_01_01_01_10) begin
      n_fail++; $display("FAIL coll_fs: got %b expected %b", fs_vec(), 9'b1_01_01_01_10);
    end
    tick(); // cycle 1: MEM owns the bus
    bif.wb_ack_i = 1'b1; bif.wb_dat_i = 32'hCAFE_F00D;
    #1;
    n_tests++;
    if ({bif.wb_cyc_o, bif.wb_we_o, bif.wb_adr_o} !== {2'b10, 32'h8000_0100}) begin
      n_fail++; $display("FAIL coll_mem_first: got %h expected %h", {bif.wb_cyc_o, bif.wb_we_o, bif.wb_adr_o}, {2'b10, 32'h8000_0100});
    end
    n_tests++;
    if (fs_vec() !== 9'b1_01_01_01_10) begin
      n_fail++; $display("FAIL coll_fs_bus: got %b expected %b", fs_vec(), 9'b1_01_01_01_10);
    end
    tick(); // cycle 2: DONE
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    n_tests++;
    if ({bif.wb_cyc_o, bif.mem_ack, bif.if_ack, bif.mem_rdata} !== {3'b010, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL coll_mem_ack: got %h expected %h", {bif.wb_cyc_o, bif.mem_ack, bif.if_ack, bif.mem_rdata}, {3'b010, 32'hCAFE_F00D});
    end
    n_tests++;
    if (fs_vec() !== 9'b1_10_00_00_00) begin
      n_fail++; $display("FAIL coll_fs_ack: got %b expected %b", fs_vec(), 9'b1_10_00_00_00);
    end
    bif.mem_req = 1'b0;
    tick(); // cycle 3: IDLE takes the fetch
    n_tests++;
    if (bif.wb_cyc_o !== 1'b0) begin
      n_fail++; $display("FAIL coll_idle: got %b expected 0", bif.wb_cyc_o);
    end
    tick(); // cycle 4
    bif.wb_ack_i = 1'b1; bif.wb_dat_i = 32'h0010_0093;
    n_tests++;
    if ({bif.wb_cyc_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o} !== {2'b10, 4'hF, 32'h8000_0004}) begin
      n_fail++; $display("FAIL coll_if_bus: got %h expected %h", {bif.wb_cyc_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_adr_o}, {2'b10, 4'hF, 32'h8000_0004});
    end
    tick(); // cycle 5
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    n_tests++;
    if ({bif.if_ack, bif.mem_ack, bif.if_rdata} !== {2'b10, 32'h0010_0093}) begin
      n_fail++; $display("FAIL coll_if_ack: got %h expected %h", {bif.if_ack, bif.mem_ack, bif.if_rdata}, {2'b10, 32'h0010_0093});
    end
    bif.if_req = 1'b0;
    tick();
  endtask

  // Three wait states: the ack lands in the last cycle before the timeout
  // would fire, so it must still complete cleanly.
  task automatic test_store();
    bif.mem_req = 1'b1; bif.mem_we = 1'b1; bif.mem_addr = 32'h8000_0200;
    bif.mem_wdata = 32'h1234_5678; bif.mem_sel = 4'b0011;
    for (int i = 1; i <= 4; i++) begin
      tick();
      if (i == 4) begin
        bif.wb_ack_i = 1'b1; bif.wb_dat_i = 32'h5555_AAAA;
      end
      n_tests++;
      if ({bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_dat_o, bif.wb_adr_o} !== {3'b111, 4'b0011, 32'h1234_5678, 32'h8000_0200}) begin
        n_fail++; $display("FAIL store_stb%0d: got %h expected %h", i, {bif.wb_cyc_o, bif.wb_stb_o, bif.wb_we_o, bif.wb_sel_o, bif.wb_dat_o, bif.wb_adr_o}, {3'b111, 4'b0011, 32'h1234_5678, 32'h8000_0200});
      end
    end
    tick();
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    n_tests++;
    if ({bif.wb_cyc_o, bif.mem_ack, bif.bus_err, bif.mem_rdata} !== {3'b010, 32'hCAFE_F00D}) begin
      n_fail++; $display("FAIL store_ack: got %h expected %h", {bif.wb_cyc_o, bif.mem_ack, bif.bus_err, bif.mem_rdata}, {3'b010, 32'hCAFE_F00D});
    end
    bif.mem_req = 1'b0; bif.mem_we = 1'b0;
    tick();
    n_tests++;
    if (bif.mem_ack !== 1'b0) begin
      n_fail++; $display("FAIL store_ack_pulse: got %b expected 0", bif.mem_ack);
    end
  endtask

  task automatic test_timeout();
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h8000_0300; bif.mem_sel = 4'hF;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if ({bif.wb_cyc_o, bif.mem_ack} !== 2'b10) begin
        n_fail++; $display("FAIL timeout_bus%0d: got %b expected 10", i, {bif.wb_cyc_o, bif.mem_ack});
      end
    end
    tick();
    // A stray ack in DONE must be ignored.
    bif.wb_ack_i = 1'b1; bif.wb_dat_i = 32'h0BAD_0BAD;
    n_tests++;
    if ({bif.wb_cyc_o, bif.mem_ack, bif.bus_err, bif.mem_rdata} !== {3'b011, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL timeout_err: got %h expected %h", {bif.wb_cyc_o, bif.mem_ack, bif.bus_err, bif.mem_rdata}, {3'b011, 32'hDEAD_BEEF});
    end
    bif.mem_req = 1'b0;
    tick();
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    n_tests++;
    if ({bif.wb_cyc_o, bif.mem_ack, bif.bus_err, bif.mem_rdata} !== {3'b000, 32'hDEAD_BEEF}) begin
      n_fail++; $display("FAIL timeout_after: got %h expected %h", {bif.wb_cyc_o, bif.mem_ack, bif.bus_err, bif.mem_rdata}, {3'b000, 32'hDEAD_BEEF});
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bif.mem_req = 1'b1; bif.mem_we = 1'b0; bif.mem_addr = 32'h8000_0400; bif.mem_sel = 4'hF;
    tick();
    n_tests++;
    if (bif.wb_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_pre: got %b expected 1", bif.wb_cyc_o);
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if ({bif.wb_cyc_o, bif.wb_stb_o, bif.mem_ack, bif.if_ack, bif.mem_rdata, bif.if_rdata} !== 68'd0) begin
      n_fail++; $display("FAIL rstmid_async: got %h expected 0", {bif.wb_cyc_o, bif.wb_stb_o, bif.mem_ack, bif.if_ack, bif.mem_rdata, bif.if_rdata});
    end
    bif.mem_req = 1'b0;
    tick(); tick();
    #2 reset = 1'b1;
    tick();
    n_tests++;
    if ({bif.wb_cyc_o, fs_vec()} !== 10'd0) begin
      n_fail++; $display("FAIL rstmid_idle: got %b expected 0", {bif.wb_cyc_o, fs_vec()});
    end
    bif.if_req = 1'b1; bif.if_addr = 32'h8000_0008;
    tick();
    bif.wb_ack_i = 1'b1; bif.wb_dat_i = 32'h0000_0073;
    n_tests++;
    if ({bif.wb_cyc_o, bif.wb_adr_o} !== {1'b1, 32'h8000_0008}) begin
      n_fail++; $display("FAIL rstmid_fetch_bus: got %h expected %h", {bif.wb_cyc_o, bif.wb_adr_o}, {1'b1, 32'h8000_0008});
    end
    tick();
    bif.wb_ack_i = 1'b0; bif.wb_dat_i = 32'h0;
    n_tests++;
    if ({bif.if_ack, bif.if_rdata} !== {1'b1, 32'h0000_0073}) begin
      n_fail++; $display("FAIL rstmid_fetch_ack: got %h expected %h", {bif.if_ack, bif.if_rdata}, {1'b1, 32'h0000_0073});
    end
    bif.if_req = 1'b0;
    tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_fetch();
    test_collision();
    test_store();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/pipe_mem_arbiter.md
Name: pipe_mem_arbiter

Overview:
- Shares the single Wishbone classic master port between two requesters: instruction fetch (IF, read-only) and the MEM stage (load/store).
- Sequences each bus transaction.
- Drives the 2-bit flush_and_stall controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC stall, so that the pipeline freezes or bubbles correctly while a bus access is outstanding.

Parameters:
- ADDR_WIDTH, 32, bus and request address width
- DATA_WIDTH, 32, bus data width
- TIMEOUT, 255, maximum cycles to wait for wb_ack_i before aborting; range 1..65535
- ERR_DATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; level, held with if_addr stable until if_ack
- if_addr  in  ADDR_WIDTH  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  DATA_WIDTH  fetched word; valid while if_ack=1, held until next IF completion
- mem_req  in  1  data request; level, held stable until mem_ack
- mem_we  in  1  1=store, 0=load
- mem_addr  in  ADDR_WIDTH  data address
- mem_wdata  in  DATA_WIDTH  store data
- mem_sel  in  4  byte enables
- mem_ack  out  1  one-cycle completion pulse
- mem_rdata  out  DATA_WIDTH  load data; valid while mem_ack=1, held otherwise
- bus_err  out  1  one-cycle pulse coincident with the ack of a timed-out access
- wb_cyc_o, wb_stb_o  out  1  Wishbone cycle and strobe (always equal)
- wb_we_o  out  1  write enable
- wb_adr_o  out  ADDR_WIDTH  address
- wb_dat_o  out  DATA_WIDTH  write data
- wb_sel_o  out  4  byte select
- wb_dat_i  in  DATA_WIDTH  read data
- wb_ack_i  in  1  slave acknowledge
- pc_stall  out  1  hold the PC
- ifid_fs, idex_fs, exmem_fs, memwb_fs  out  2  per-register controls: [1]=flush, [0]=stall

Behaviour:
- States are IDLE, BUS_IF, BUS_MEM and DONE. All bus outputs, acks, rdata and bus_err are registered.
- Reset (reset=0, asynchronous):
  - state goes to IDLE; all wb_* outputs, acks, bus_err, rdata and the timeout counter go to 0.
  - Cyc/stb drop immediately, even mid-transaction.
- IDLE:
  - mem_req=1: latch mem_addr/we/wdata/sel into the wb_* registers, go to BUS_MEM.
  - else if_req=1: latch if_addr with we=0 and sel=4'hF, go to BUS_IF.
  - Otherwise stay in IDLE.
  - If both requests are present, MEM wins. IF is served on the next IDLE.
- BUS_IF / BUS_MEM:
  - cyc=stb=1; the timeout counter increments each cycle.
  - On wb_ack_i=1: capture wb_dat_i into the owning rdata register (loads and fetches only; stores leave mem_rdata unchanged). Deassert cyc/stb, go to DONE.
  - Counter reaching TIMEOUT with no ack: deassert cyc/stb, load ERR_DATA into rdata (reads), set the bus_err flag, go to DONE.
  - wb_ack_i is ignored outside bus states.
- DONE (exactly one cycle):
  - Pulse the owner's ack, plus bus_err if flagged.
  - Requests are ignored in this cycle; return to IDLE.
- Latency:
  - Request seen in IDLE at cycle 0 gives cyc=1 from cycle 1.
  - Ack arriving at cycle N gives if_ack/mem_ack=1 at cycle N+1 and IDLE at N+2.
  - Minimum request-to-ack latency is 2 cycles.
- Pipeline control is combinational from the requests and their acks:
  - mem_busy = mem_req & ~mem_ack; if_busy = if_req & ~if_ack.
  - mem_busy: pc_stall=1, ifid=01, idex=01, exmem=01, memwb=10 (WB receives bubbles).
  - else if_busy: pc_stall=1, ifid=10 (bubble into ID), idex=exmem=memwb=00.
  - else: all 0.
  - On the ack cycle the pipeline advances normally. The requester must drop or change its request at that edge.
- No pipelining of bus cycles; at most one outstanding transaction.

Test Plan:
1. Fetch: if_req=1, if_addr=0x8000_0000, slave acks 1 cycle after stb with 0x0000_0013 -> cyc high cycles 1-2, if_ack at cycle 3 with if_rdata=0x13; ifid_fs=10 and pc_stall=1 during cycles 0-2, then 00 at the ack cycle.
2. Collision: if_req and mem_req (load 0x8000_0100) asserted in the same cycle -> MEM transaction first. During it ifid/idex/exmem=01, memwb=10, pc_stall=1. The IF transaction starts on the cycle after the DONE that follows mem_ack.
3. Store: mem_we=1, mem_sel=4'b0011, mem_wdata=0x1234_5678, slave acks with 3 wait cycles -> wb_we_o=1, wb_sel_o=0011, wb_dat_o=0x1234_5678 stable for all 4 stb cycles; mem_ack one cycle; mem_rdata unchanged.
4. Timeout: TIMEOUT=4, slave never acks a load -> cyc drops after 4 bus cycles; mem_ack=1 and bus_err=1 in the same cycle; mem_rdata=0xDEAD_BEEF.
5. Reset mid-transaction: assert reset=0 while BUS_MEM with cyc=1 -> cyc/stb/acks drop without waiting for a clock. After release, an idle bus, all fs=00 and a fresh if_req is served normally.
